// File: rtl/ram_rd_check.sv
// ram_rd_check: monitors a RAM's write/read traffic against a shadow copy and flags read mismatches.
// Latency: a compare resolves RD_LAT cycles after the read address; all status outputs register one edge later.
// Backpressure: none; a passive observer that samples every cycle and never stalls the RAM driver.
module ram_rd_check #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              ram_en,
  input  logic              ram_we,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_wr_data,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              err_flag,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_got,
  output logic              pass_done,
  output logic              pass_ok
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE = 2'd0, WR = 2'd1, RD = 2'd2} state_t;

  state_t state_q, state_d;
  logic   enter_rd;

  logic              wr_cyc, rd_cyc;
  logic [DATA_W-1:0] shadow [DEPTH];
  logic [DEPTH-1:0]  wvalid;

  // Read-tracking pipeline; the expected word is captured at issue time so
  // later writes to the same address cannot disturb an in-flight compare.
  logic              p_rd   [RD_LAT];
  logic              p_wv   [RD_LAT];
  logic [ADDR_W-1:0] p_addr [RD_LAT];
  logic [DATA_W-1:0] p_exp  [RD_LAT];

  logic              e_rd, e_wv;
  logic [ADDR_W-1:0] e_addr;
  logic [DATA_W-1:0] e_exp;
  logic              mismatch, last_cmp;
  logic              pass_bad;

  assign wr_cyc = ram_en &  ram_we;
  assign rd_cyc = ram_en & ~ram_we;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: follows the bus activity sampled this cycle
  always_comb begin
    state_d = IDLE;
    if (ram_en) state_d = ram_we ? WR : RD;
  end

  // FSM outputs: a new read phase begins on the edge that enters RD
  always_comb begin
    enter_rd = 1'b0;
    if (state_d == RD && state_q != RD) enter_rd = 1'b1;
  end

  // Shadow data; contents survive reset, the valid bits gate their use
  always_ff @(posedge clk) begin
    if (wr_cyc) shadow[ram_addr] <= ram_wr_data;
  end

  // Per-word written-valid bits, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         wvalid <= '0;
    else if (wr_cyc) wvalid[ram_addr] <= 1'b1;
  end

  // Delay pipeline shifting read descriptors toward the compare point
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        p_rd[i]   <= 1'b0;
        p_wv[i]   <= 1'b0;
        p_addr[i] <= '0;
        p_exp[i]  <= '0;
      end
    end else begin
      p_rd[0]   <= rd_cyc;
      p_wv[0]   <= rd_cyc & wvalid[ram_addr];
      p_addr[0] <= ram_addr;
      p_exp[0]  <= shadow[ram_addr];
      for (int i = 1; i < RD_LAT; i++) begin
        p_rd[i]   <= p_rd[i-1];
        p_wv[i]   <= p_wv[i-1];
        p_addr[i] <= p_addr[i-1];
        p_exp[i]  <= p_exp[i-1];
      end
    end
  end

  assign e_rd   = p_rd[RD_LAT-1];
  assign e_wv   = p_wv[RD_LAT-1];
  assign e_addr = p_addr[RD_LAT-1];
  assign e_exp  = p_exp[RD_LAT-1];

  // Unwritten words emerge with e_wv clear and are never compared
  assign mismatch = e_rd & e_wv & (ram_rd_data != e_exp);
  assign last_cmp = e_rd & (e_addr == {ADDR_W{1'b1}});

  // Per-pass badness: cleared entering RD, a mismatch on that same edge still counts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pass_bad <= 1'b0;
    else     pass_bad <= mismatch | (pass_bad & ~enter_rd);
  end

  // Pass-end pulse, including a mismatch found on the final compare itself
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_done <= 1'b0;
      pass_ok   <= 1'b0;
    end else begin
      pass_done <= last_cmp;
      pass_ok   <= last_cmp & ~(pass_bad | mismatch);
    end
  end

  // Sticky error status; clr wipes history but a simultaneous mismatch becomes the new first error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_flag       <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      first_err_exp  <= '0;
      first_err_got  <= '0;
    end else if (clr) begin
      err_flag       <= mismatch;
      err_cnt        <= {15'd0, mismatch};
      first_err_addr <= mismatch ? e_addr      : '0;
      first_err_exp  <= mismatch ? e_exp       : '0;
      first_err_got  <= mismatch ? ram_rd_data : '0;
    end else if (mismatch) begin
      err_flag <= 1'b1;
      if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      if (!err_flag) begin
        first_err_addr <= e_addr;
        first_err_exp  <= e_exp;
        first_err_got  <= ram_rd_data;
      end
    end
  end

endmodule

// File: tb/tb_ram_rd_check.sv
// Directed bench for ram_rd_check with a one-cycle-latency RAM model whose
// read data equals the address unless a corruption is requested.
module tb_ram_rd_check;

  logic       clk = 1'b0;
  logic       rst, clr, ram_en, ram_we;
  logic [4:0] ram_addr;
  logic [7:0] ram_wr_data, ram_rd_data;
  logic       err_flag, pass_done, pass_ok;
  logic [15:0] err_cnt;
  logic [4:0] first_err_addr;
  logic [7:0] first_err_exp, first_err_got;

  int passed = 0;
  int total  = 0;

  ram_rd_check #(.ADDR_W(5), .DATA_W(8), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data),
    .err_flag(err_flag), .err_cnt(err_cnt),
    .first_err_addr(first_err_addr), .first_err_exp(first_err_exp),
    .first_err_got(first_err_got), .pass_done(pass_done), .pass_ok(pass_ok)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ram_en = 1'b0; ram_we = 1'b0; clr = 1'b0;
  endtask

  // Write data = address to every word, then one idle cycle
  task automatic write_pass();
    for (int i = 0; i < 32; i++) begin
      step();
      ram_en = 1'b1; ram_we = 1'b1; ram_addr = i[4:0]; ram_wr_data = i[7:0];
    end
    step();
    idle();
  endtask

  // Read 0..31; the data for the previous cycle's address arrives each cycle.
  // ca/cb: corrupted addresses with values va/vb; clr_at: iteration to pulse clr.
  task automatic read_pass(input int ca, input logic [7:0] va,
                           input int cb, input logic [7:0] vb, input int clr_at);
    for (int i = 0; i <= 32; i++) begin
      step();
      clr = (i == clr_at);
      if (i < 32) begin
        ram_en = 1'b1; ram_we = 1'b0; ram_addr = i[4:0];
      end else begin
        ram_en = 1'b0;
      end
      if (i > 0) begin
        ram_rd_data = 8'(i - 1);
        if (i - 1 == ca) ram_rd_data = va;
        if (i - 1 == cb) ram_rd_data = vb;
      end
    end
    step();
    idle();
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; ram_en = 1'b0; ram_we = 1'b0;
    ram_addr = '0; ram_wr_data = '0; ram_rd_data = '0;
    step(); step();
    chk("rst_err_flag", err_flag, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_pass_done", pass_done, 0);
    chk("rst_first_addr", first_err_addr, 0);
    rst = 1'b0;

    // Reads of never-written words: nothing compared, pass still completes cleanly
    read_pass(99, 8'h00, 99, 8'h00, -1);
    chk("unwritten_pass_done", pass_done, 1);
    chk("unwritten_pass_ok", pass_ok, 1);
    chk("unwritten_err_cnt", err_cnt, 0);
    chk("unwritten_err_flag", err_flag, 0);
    step();
    chk("unwritten_pulse_width", pass_done, 0);

    // Clean write/read pass
    write_pass();
    read_pass(99, 8'h00, 99, 8'h00, -1);
    chk("clean_pass_done", pass_done, 1);
    chk("clean_pass_ok", pass_ok, 1);
    chk("clean_err_flag", err_flag, 0);
    chk("clean_err_cnt", err_cnt, 0);
    step();
    chk("clean_pulse_width", pass_done, 0);

    // Address 7 returns A5
    read_pass(7, 8'hA5, 99, 8'h00, -1);
    chk("bad7_pass_done", pass_done, 1);
    chk("bad7_pass_ok", pass_ok, 0);
    chk("bad7_err_cnt", err_cnt, 1);
    chk("bad7_err_flag", err_flag, 1);
    chk("bad7_first_addr", first_err_addr, 7);
    chk("bad7_first_exp", first_err_exp, 8'h07);
    chk("bad7_first_got", first_err_got, 8'hA5);

    // Plain clr
    step(); clr = 1'b1;
    step(); clr = 1'b0;
    chk("clr_err_flag", err_flag, 0);
    chk("clr_err_cnt", err_cnt, 0);
    chk("clr_first_got", first_err_got, 0);

    // Corrupt 3 and 9; clr lands in the cycle that address 9's data is compared
    read_pass(3, 8'hA5, 9, 8'h5A, 10);
    chk("clrhit_err_cnt", err_cnt, 1);
    chk("clrhit_err_flag", err_flag, 1);
    chk("clrhit_first_addr", first_err_addr, 9);
    chk("clrhit_first_exp", first_err_exp, 8'h09);
    chk("clrhit_first_got", first_err_got, 8'h5A);
    chk("clrhit_pass_ok", pass_ok, 0);

    // Reset in the middle of a read phase
    for (int i = 0; i < 16; i++) begin
      step();
      ram_en = 1'b1; ram_we = 1'b0; ram_addr = i[4:0];
      if (i > 0) ram_rd_data = 8'(i - 1);
    end
    #2 rst = 1'b1;
    #1;
    chk("midrst_err_flag", err_flag, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    chk("midrst_first_addr", first_err_addr, 0);
    chk("midrst_first_got", first_err_got, 0);
    chk("midrst_pass_done", pass_done, 0);
    idle();
    step(); step();
    rst = 1'b0;
    write_pass();
    read_pass(99, 8'h00, 99, 8'h00, -1);
    chk("postrst_pass_done", pass_done, 1);
    chk("postrst_pass_ok", pass_ok, 1);
    chk("postrst_err_cnt", err_cnt, 0);

    // Saturation: address 0 holds 0, every read returns EE
    ram_rd_data = 8'hEE;
    for (int i = 0; i < 65534; i++) begin
      step();
      ram_en = 1'b1; ram_we = 1'b0; ram_addr = 5'd0;
    end
    step(); idle();
    step();
    chk("sat_err_cnt_fffe", err_cnt, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      step();
      ram_en = 1'b1; ram_we = 1'b0; ram_addr = 5'd0;
    end
    step(); idle();
    step();
    chk("sat_err_cnt_ffff", err_cnt, 16'hFFFF);
    step(); step();
    chk("sat_err_cnt_hold", err_cnt, 16'hFFFF);
    chk("sat_err_flag", err_flag, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ram_rd_check.md
RAM_RD_CHECK -- requirements
Module: ram_rd_check

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 5, RAM address width; DATA_W, default 8, RAM data width; RD_LAT, default 1, allowed 1..2, cycles from read address to valid ram_rd_data.
REQ-002 clk  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 clr  input  1  synchronous clear of the sticky error status and counters.
REQ-005 ram_en  input  1  RAM enable, monitored from the upstream RAM driver.
REQ-006 ram_we  input  1  RAM write enable; 1 = write cycle, 0 = read cycle when ram_en=1.
REQ-007 ram_addr  input  ADDR_W  RAM address.
REQ-008 ram_wr_data  input  DATA_W  RAM write data.
REQ-009 ram_rd_data  input  DATA_W  RAM read data, valid RD_LAT cycles after its read address.
REQ-010 err_flag  output  1  sticky: a mismatch has occurred since reset or clr.
REQ-011 err_cnt  output  16  mismatch count, saturating at 16'hFFFF.
REQ-012 first_err_addr  output  ADDR_W  address of the first mismatch since reset or clr.
REQ-013 first_err_exp  output  DATA_W  expected data at the first mismatch.
REQ-014 first_err_got  output  DATA_W  received data at the first mismatch.
REQ-015 pass_done  output  1  one-cycle pulse when the last-address read compare completes.
REQ-016 pass_ok  output  1  valid with pass_done; 1 = no mismatch during that read phase.

Function
REQ-017 The block SHALL keep a shadow array of 2^ADDR_W words with one written-valid bit per word.
REQ-018 Shadow write: on ram_en=1 and ram_we=1, the block SHALL store ram_wr_data at ram_addr and set that word's valid bit in the same edge.
REQ-019 Read tracking: on ram_en=1 and ram_we=0, the block SHALL push {ram_addr, valid bit} into an RD_LAT-deep delay pipeline.
REQ-020 Compare: when a pipeline entry emerges with its valid bit set, the block SHALL compare ram_rd_data to the shadow word at the delayed address.
REQ-021 Compare timing: the compare SHALL use the shadow content as of the cycle the read was issued, so a write issued after the read does not affect that compare.
REQ-022 Unwritten words: an emerging entry with its valid bit clear SHALL NOT be compared or counted.
REQ-023 Phase FSM states SHALL be IDLE, WR and RD.
REQ-024 FSM transitions: ram_en=0 -> IDLE; ram_en=1 and ram_we=1 -> WR; ram_en=1 and ram_we=0 -> RD; a transition takes effect on the edge after the inputs are sampled.
REQ-025 Per-pass flag: an internal pass_bad flag SHALL clear on every transition into RD and SHALL set on any mismatch.
REQ-026 Pass end: when a compare of address 2^ADDR_W-1 completes, pass_done SHALL pulse for exactly one cycle, with pass_ok = NOT (pass_bad OR current-cycle mismatch).
REQ-027 Mismatch update: on a mismatch, err_cnt SHALL increment (saturating at 16'hFFFF) and err_flag SHALL go high on the next edge.
REQ-028 First-error capture: the first_err_* registers SHALL load only on a mismatch while err_flag=0, then hold.
REQ-029 clr SHALL zero err_flag, err_cnt and the first_err_* registers.
REQ-030 clr SHALL NOT alter the shadow array, the valid bits, the pipeline or the FSM.
REQ-031 clr and a mismatch in the same cycle SHALL leave err_cnt=1 and err_flag=1, with the first_err_* registers holding the new mismatch.
REQ-032 Address wrap: the block SHALL track addresses modulo 2^ADDR_W; a read phase of any length and any address order SHALL be checked.
REQ-033 Output latency: all outputs SHALL be registered, and no output SHALL depend combinationally on any input.

Reset
REQ-034 While rst=1, all outputs, the FSM (IDLE), the pipeline and all valid bits SHALL be 0; shadow data contents are don't-care.
REQ-035 A reset asserted mid-phase SHALL discard in-flight compares, and reads after reset SHALL be unchecked until their words are rewritten.

Verification
REQ-036 Write 0..31 to addresses 0..31, then read 0..31 with a correct RD_LAT=1 model -> pass_done one cycle after the address-31 read, pass_ok=1, err_flag=0, err_cnt=0.
REQ-037 Same sequence with the model returning 8'hA5 at address 7 -> err_cnt=1, first_err_addr=7, first_err_exp=7, first_err_got=8'hA5, pass_ok=0.
REQ-038 Corrupt addresses 3 and 9, then drive clr in the same cycle as the second mismatch -> err_cnt=1, first_err_addr=9.
REQ-039 Read with no prior write after reset -> no compares, err_cnt=0, pass_done pulses with pass_ok=1.
REQ-040 Assert rst halfway through the read phase -> all outputs 0 immediately, and a subsequent full write/read pass gives pass_ok=1.
REQ-041 Force err_cnt to 16'hFFFE, then inject 3 mismatches -> err_cnt=16'hFFFF and holds.
